// File: rtl/pc_req_ctrl_pkg.sv
// Shared types and constants for the PC request controller.
package pc_req_ctrl_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] DEFAULT_BOOT_ADDR = 32'h0000_0080;

    typedef enum logic [1:0] {
        FETCH,
        WAIT_CMD,
        SETUP,
        ASSERT
    } pc_req_state_e;

endpackage

// File: rtl/pc_req_ctrl.sv
// Holds the PC, fetches it, and runs a setup/assert req handshake with pc_alu per decode command.
// Command accepted in cycle N: SETUP in N+1, req high ALU_LAT cycles, new PC fetched at N+2+ALU_LAT; stalls on fetch_ready_i/cmd_valid_i.
module pc_req_ctrl
    import pc_req_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] BOOT_ADDR = DEFAULT_BOOT_ADDR,
    parameter int unsigned     ALU_LAT   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [PC_W-1:0] fetch_addr_o,
    output logic            fetch_valid_o,
    input  logic            fetch_ready_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_taken_i,
    input  logic [PC_W-1:0] cmd_offset_i,
    input  logic [PC_W-1:0] cmd_op_i,
    output logic            req_o,
    output logic [PC_W-1:0] operand_a_o,
    output logic [PC_W-1:0] operand_b_o,
    output logic            branch_bool_o,
    output logic [PC_W-1:0] op_bool_o,
    input  logic [PC_W-1:0] pc_next_i,
    output logic [PC_W-1:0] retired_o,
    output logic            misalign_o
);

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    pc_req_state_e   state;
    logic [3:0]      lat_cnt;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] opb_q;
    logic [PC_W-1:0] op_q;
    logic            taken_q;
    logic            req_q;
    logic [PC_W-1:0] retired_q;
    logic            misalign_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= FETCH;
            lat_cnt    <= 4'd0;
            pc_q       <= BOOT_ADDR;
            opb_q      <= '0;
            op_q       <= '0;
            taken_q    <= 1'b0;
            req_q      <= 1'b0;
            retired_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (fetch_ready_i) begin
                        state <= WAIT_CMD;
                    end
                end
                WAIT_CMD: begin
                    if (cmd_valid_i) begin
                        taken_q <= cmd_taken_i;
                        opb_q   <= cmd_offset_i;
                        op_q    <= cmd_op_i;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    // Operands have now been stable a full cycle, so req may rise.
                    lat_cnt <= LAT_M1;
                    req_q   <= 1'b1;
                    state   <= ASSERT;
                end
                ASSERT: begin
                    if (lat_cnt == 4'd0) begin
                        pc_q      <= {pc_next_i[PC_W-1:2], 2'b00};
                        retired_q <= retired_q + 32'd1;
                        if (pc_next_i[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                        end
                        req_q <= 1'b0;
                        state <= FETCH;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign fetch_addr_o  = pc_q;
    assign fetch_valid_o = (state == FETCH);
    assign cmd_ready_o   = (state == WAIT_CMD);
    assign req_o         = req_q;
    assign operand_a_o   = pc_q;
    assign operand_b_o   = opb_q;
    assign branch_bool_o = taken_q;
    assign op_bool_o     = op_q;
    assign retired_o     = retired_q;
    assign misalign_o    = misalign_q;

endmodule

// File: doc/pc_req_ctrl.md
# pc_req_ctrl

Clocked initiator for the asynchronous-style `pc_alu` request interface. It holds the architectural PC, presents it to instruction fetch, and accepts next-PC commands from decode. It sequences the `pc_alu` req phases, setting operands up while req is low and then raising req. It captures `pc_next` back into the PC register. It sits between decode, `pc_alu` and the instruction-memory port.

## Interface
Parameters:
- `BOOT_ADDR`, 32'h0000_0080: PC value after reset.
- `ALU_LAT`, 1: cycles `req_o` stays high before `pc_next_i` is sampled; legal range 1..15.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous active-high reset.
- `fetch_addr_o`  out  32  current PC.
- `fetch_valid_o`  out  1  fetch address valid.
- `fetch_ready_i`  in  1  memory accepts fetch.
- `cmd_valid_i`  in  1  decode next-PC command valid.
- `cmd_ready_o`  out  1  controller accepts command.
- `cmd_taken_i`  in  1  branch taken flag.
- `cmd_offset_i`  in  32  offset or target operand.
- `cmd_op_i`  in  32  `pc_alu` op selector, passed through unchanged.
- `req_o`  out  1  `pc_alu` request.
- `operand_a_o`  out  32  PC to `pc_alu`.
- `operand_b_o`  out  32  latched `cmd_offset_i`.
- `branch_bool_o`  out  1  latched `cmd_taken_i`.
- `op_bool_o`  out  32  latched `cmd_op_i`.
- `pc_next_i`  in  32  `pc_alu` result.
- `retired_o`  out  32  count of completed PC updates.
- `misalign_o`  out  1  sticky: a captured `pc_next_i` had bits[1:0] != 0.

## Operation
- FSM states: FETCH, WAIT_CMD, SETUP, ASSERT.
- **FETCH**
  - `fetch_valid_o`=1 and `fetch_addr_o`=pc_q.
  - On `fetch_ready_i`, go to WAIT_CMD.
- **WAIT_CMD**
  - `cmd_ready_o`=1.
  - On `cmd_valid_i`, latch taken/offset/op into operand registers and go to SETUP.
- **SETUP**
  - `req_o`=0 and operands stable.
  - Load the latency counter with `ALU_LAT`-1, then go to ASSERT.
- **ASSERT**
  - `req_o`=1 and operands held stable.
  - Count down.
  - At the clock edge ending the cycle where the count is 0:
    - pc_q <= {`pc_next_i`[31:2], 2'b00};
    - `retired_o` increments and wraps from 2^32-1 to 0;
    - if `pc_next_i`[1:0] != 0, `misalign_o` <= 1;
    - `req_o` <= 0 and the FSM goes to FETCH.
- `operand_a_o` always equals pc_q. pc_q changes only on capture.
- `cmd_valid_i` outside WAIT_CMD is ignored (`cmd_ready_o`=0).
- `fetch_ready_i` outside FETCH is ignored.
- `pc_next_i` is sampled only at the final ASSERT edge. Glitches at other times have no effect.
- Reset at any time, including mid-ASSERT:
  - `req_o` drops immediately;
  - FSM goes to FETCH;
  - pc_q = `BOOT_ADDR`;
  - counters and `misalign_o` clear.

## Timing
- Reset values:
  - `fetch_addr_o`=`BOOT_ADDR`, `fetch_valid_o`=1 (FETCH state).
  - `cmd_ready_o`=0, `req_o`=0.
  - `operand_a_o`=`BOOT_ADDR`; `operand_b_o`, `op_bool_o` = 0; `branch_bool_o`=0.
  - `retired_o`=0, `misalign_o`=0.
- All outputs are registered or decoded from the registered state. There are no combinational input-to-output paths.
- Cycle sequence from command acceptance:
  - Command accepted at edge N. SETUP is cycle N+1.
  - `req_o` rises at edge N+2 and stays high for exactly `ALU_LAT` cycles.
  - The new `fetch_addr_o` is valid at edge N+2+`ALU_LAT`.
- Fetch handshake completing at edge F makes `cmd_ready_o`=1 from F.
- Operands are stable at least one full cycle before the `req_o` rising edge and throughout req high.

## Structure
- Shared package `pkg` gains:
  - typedef `pc_req_state_e` {FETCH, WAIT_CMD, SETUP, ASSERT};
  - constant `PC_W`=32;
  - default `BOOT_ADDR`.
- Single module. The FSM, latency counter, PC register and retire counter are inline; no sub-module is warranted.
- The bench instantiates `pc_req_ctrl` against a behavioural `pc_alu` stub:
  - pc_next = branch_bool ? operand_a+operand_b : operand_a+4;
  - the stub ignores `op_bool`.

## Test plan
- **Reset/boot:** hold `rst_i` 3 cycles, then release. Required: `fetch_addr_o`=0x80, `fetch_valid_o`=1, `req_o`=0, `retired_o`=0.
- **Sequential step:** fetch accepted, cmd taken=0, offset=1. Required:
  - `req_o` low for 1 cycle with `operand_a_o`=0x80, then high for `ALU_LAT` cycles;
  - `fetch_addr_o`=0x84 at N+3 (`ALU_LAT`=1);
  - `retired_o`=1.
- **Taken branch:** PC=0x1FC, taken=1, offset=0x100. Required: next `fetch_addr_o`=0x2FC, `branch_bool_o`=1 during req high.
- **Misaligned result:** taken=1, offset=1 from 0x80. Required: pc_q=0x80 (0x81 with low bits forced to 0), `misalign_o`=1 and staying 1 afterwards.
- **Backpressure/ignore:**
  - hold `fetch_ready_i`=0 for 5 cycles while pulsing `cmd_valid_i`. Required: `cmd_ready_o`=0, no req, PC unchanged;
  - rerun with `ALU_LAT`=4. Required: req high exactly 4 cycles.
- **Reset mid-ASSERT:** assert `rst_i` during req high. Required: `req_o`=0 in the same cycle without waiting for a clock, PC=0x80, `retired_o`=0.
